// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The signed overflow flag exists only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERSUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b,
                  input  busy, done, diff, borrow_out, ovf);
  modport slave  (input  start, a, b,
                  output busy, done, diff, borrow_out, ovf);
`else
  modport master (output start, a, b,
                  input  busy, done, diff, borrow_out);
  modport slave  (input  start, a, b,
                  output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock,
// using a single full-subtractor slice with a registered borrow.
// Start/done handshake; a start is taken only in IDLE.
// Optional feature macro: SERSUB_OVF_EN adds the signed overflow flag (ovf).
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             done_q, done_d;
`ifdef SERSUB_OVF_EN
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor slice on the current operand LSBs and the stored borrow
  logic a0, b0, dbit, br_next;
  assign a0      = a_q[0];
  assign b0      = b_q[0];
  assign dbit    = a0 ^ b0 ^ br_q;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  // State and datapath registers; everything clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
`ifdef SERSUB_OVF_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath update; results are published on the last shift
  // so that diff/borrow_out are already valid in the cycle done is high
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
`ifdef SERSUB_OVF_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERSUB_OVF_EN
          am_d    = bus.a[WIDTH-1];
          bm_d    = bus.b[WIDTH-1];
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        res_d = WIDTH'({dbit, res_q} >> 1);
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = WIDTH'({dbit, res_q} >> 1);
          bo_d    = br_next;
          done_d  = 1'b1;
`ifdef SERSUB_OVF_EN
          // The last difference bit lands in the result MSB
          ovf_d   = (am_q ^ bm_q) & (dbit ^ am_q);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;
`ifdef SERSUB_OVF_EN
  assign bus.ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): reset state, latency,
// result/borrow/overflow vectors, held start, mid-op operand change,
// mid-op reset abort and a random-pair sweep against a - b.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation; expected values supplied by caller
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    @(negedge clk);
    bus.a     = ta;
    bus.b     = tb_v;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~ta;
    bus.b     = ~tb_v;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(WIDTH));
    chk("diff", 32'(bus.diff), 32'(ed));
    chk("borrow_out", 32'(bus.borrow_out), 32'(eb));
`ifdef SERSUB_OVF_EN
    chk("ovf", 32'(bus.ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected X expectation");
`endif
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("idle_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [8:0] ref_v;
    logic [7:0] ra, rb;
    logic       rovf;
    int nd, last, chg_at, dcnt;

    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERSUB_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

    // Start held high: back-to-back ops every WIDTH+2 cycles, a changed mid-op
    @(negedge clk);
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    nd     = 0;
    last   = 0;
    chg_at = -1;
    for (int e = 0; e < 60 && nd < 3; e++) begin
      @(posedge clk);
      #1;
      if (e == chg_at) bus.a = 8'h20;
      if (bus.done) begin
        nd++;
        chk("held_diff", 32'(bus.diff), (nd < 3) ? 32'h0F : 32'h1F);
        if (nd > 1) chk("held_interval", 32'(e - last), 32'(WIDTH + 2));
        if (nd == 1) chg_at = e + 3;
        last = e;
      end
    end
    chk("held_done_count", 32'(nd), 32'd3);
    bus.start = 1'b0;
    repeat (WIDTH + 3) @(posedge clk);
    #1;
    chk("held_idle", 32'(bus.busy), 32'd0);

    // Reset mid-operation aborts without a done
    @(negedge clk);
    bus.a     = 8'h5A;
    bus.b     = 8'h3C;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    chk("no_stale_done", 32'(dcnt), 32'd0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

    // Random operand pairs against the a - b reference
    for (int i = 0; i < 300; i++) begin
      ra    = 8'($urandom_range(0, 255));
      rb    = 8'($urandom_range(0, 255));
      ref_v = {1'b0, ra} - {1'b0, rb};
      rovf  = (ra[7] != rb[7]) && (ref_v[7] != ra[7]);
      run_op(ra, rb, ref_v[7:0], ref_v[8], rovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
